data_memory_arbiter: RTL and testbench

//  Shares one single-port data_memory (1-cycle registered read) between NREQ requesters, e.g. DMA loader and MAC engine.

---
 rtl/data_memory_arbiter_pkg.sv | 38 +++
 rtl/data_memory.sv | 24 ++
 rtl/data_memory_arbiter_pick.sv | 24 ++
 rtl/data_memory_arbiter.sv | 146 ++++++++++++++
 tb/tb_data_memory_arbiter.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/data_memory_arbiter_pkg.sv
// Shared types and the rotating-priority search used by the data memory arbiter.
package data_mem_arb_pkg;

    // Arbiter FSM encoding
    typedef logic [0:0] arb_state_e;
    localparam arb_state_e ARB    = 1'b0;
    localparam arb_state_e LOCKED = 1'b1;

    // Upper bound on requesters the generic search handles
    localparam int PICK_MAX = 32;

    typedef struct packed {
        logic found;
        int   idx;
    } pick_t;

    // First valid index found when scanning ptr, ptr+1, ... modulo nreq.
    // Scanning offsets from high to low lets the smallest offset win.
    function automatic pick_t rr_pick(input logic [PICK_MAX-1:0] valid,
                                      input int ptr,
                                      input int nreq);
        pick_t r;
        int    j;
        r.found = 1'b0;
        r.idx   = 0;
        for (int k = PICK_MAX - 1; k >= 0; k--) begin
            if (k < nreq) begin
                j = (ptr + k) % nreq;
                if (valid[j]) begin
                    r.found = 1'b1;
                    r.idx   = j;
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/data_memory.sv
// Single-port data memory with a one-cycle registered read.
// A write lands at the clock edge; the read port returns the old contents
// for an access to the same address in the same cycle.
module data_memory #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 256,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    addr,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Write on we, always register the addressed word for reading
    always_ff @(posedge clk) begin
        if (we) mem[addr] <= wdata;
        rdata <= mem[addr];
    end

endmodule

// File: rtl/data_memory_arbiter_pick.sv
// Combinational rotating-priority picker: grants the first valid requester
// at or after ptr, wrapping around.
module rr_priority_pick
    import data_mem_arb_pkg::*;
#(
    parameter  int NREQ = 2,
    localparam int IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] valid,
    input  logic [IW-1:0]   ptr,
    output logic [IW-1:0]   gnt_idx,
    output logic            gnt_any
);

    pick_t pick;

    // Rotate-and-search over the valid vector
    always_comb begin
        pick    = rr_pick(PICK_MAX'(valid), 32'(ptr), NREQ);
        gnt_idx = IW'(pick.idx);
        gnt_any = pick.found;
    end

endmodule

// File: rtl/data_memory_arbiter.sv
// Round-robin arbiter sharing one single-port data memory between NREQ
// requesters, with an optional bus lock capped at MAX_BURST accepted beats.
// Read data is routed back to the requester that issued the read one cycle
// after acceptance.
module data_memory_arbiter
    import data_mem_arb_pkg::*;
#(
    parameter  int WIDTH     = 8,
    parameter  int DEPTH     = 256,
    parameter  int NREQ      = 2,
    parameter  int MAX_BURST = 16,
    localparam int AW        = $clog2(DEPTH),
    localparam int IW        = $clog2(NREQ),
    localparam int CW        = $clog2(MAX_BURST + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ-1:0]       req_we,
    input  logic [NREQ-1:0]       req_lock,
    input  logic [NREQ*AW-1:0]    req_addr,
    input  logic [NREQ*WIDTH-1:0] req_wdata,
    output logic [NREQ-1:0]       req_ready,
    output logic [NREQ-1:0]       rsp_valid,
    output logic [WIDTH-1:0]      rsp_rdata,
    output logic                  mem_we,
    output logic [AW-1:0]         mem_addr,
    output logic [WIDTH-1:0]      mem_wdata,
    input  logic [WIDTH-1:0]      mem_rdata,
    output logic [IW-1:0]         owner,
    output logic                  locked
);

    arb_state_e    state_q;
    logic [IW-1:0] owner_q;
    logic [IW-1:0] rr_ptr_q;
    logic [CW-1:0] beat_cnt_q;
    logic [CW-1:0] beat_cnt_inc;
    logic          rd_pend_q;
    logic [IW-1:0] rd_id_q;
    logic [AW-1:0] addr_q;

    logic [IW-1:0] pick_idx;
    logic          pick_any;
    logic [IW-1:0] gnt_idx;
    logic [IW-1:0] gnt_next;
    logic          gnt_any;
    logic          accept;

    rr_priority_pick #(.NREQ(NREQ)) u_pick (
        .valid   (req_valid),
        .ptr     (rr_ptr_q),
        .gnt_idx (pick_idx),
        .gnt_any (pick_any)
    );

    // Grant selection: round-robin in ARB, owner only while LOCKED.
    // Nothing is accepted while reset is asserted.
    always_comb begin
        gnt_idx = pick_idx;
        gnt_any = pick_any;
        if (state_q == LOCKED) begin
            gnt_idx = owner_q;
            gnt_any = req_valid[owner_q];
        end
        accept       = gnt_any & rst_n;
        gnt_next     = (gnt_idx == IW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
        beat_cnt_inc = beat_cnt_q + 1'b1;
    end

    // Memory and handshake drive; address parks on the last accepted beat
    always_comb begin
        req_ready = accept ? (NREQ'(1) << gnt_idx) : '0;
        mem_we    = accept & req_we[gnt_idx];
        mem_addr  = accept ? req_addr[gnt_idx*AW +: AW] : addr_q;
        mem_wdata = req_wdata[gnt_idx*WIDTH +: WIDTH];
    end

    // Arbitration FSM: lock entry, beat counting and release
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ARB;
            owner_q    <= '0;
            rr_ptr_q   <= '0;
            beat_cnt_q <= '0;
        end else if (state_q == ARB) begin
            if (accept) begin
                // A one-beat cap means the entry beat already exhausts the lock
                if (req_lock[gnt_idx] && MAX_BURST > 1) begin
                    state_q    <= LOCKED;
                    owner_q    <= gnt_idx;
                    beat_cnt_q <= CW'(1);
                end else begin
                    rr_ptr_q <= gnt_next;
                end
            end
        end else begin
            if (accept) begin
                if (!req_lock[owner_q] || beat_cnt_inc == CW'(MAX_BURST)) begin
                    state_q    <= ARB;
                    rr_ptr_q   <= gnt_next;
                    beat_cnt_q <= '0;
                end else begin
                    beat_cnt_q <= beat_cnt_inc;
                end
            end else if (!req_lock[owner_q]) begin
                state_q    <= ARB;
                rr_ptr_q   <= gnt_next;
                beat_cnt_q <= '0;
            end
        end
    end

    // One-deep response tag: which requester the next mem_rdata belongs to
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_pend_q <= 1'b0;
            rd_id_q   <= '0;
        end else begin
            rd_pend_q <= accept & ~req_we[gnt_idx];
            rd_id_q   <= gnt_idx;
        end
    end

    // Remember the last accepted address for the idle bus
    always_ff @(posedge clk) begin
        if (accept) addr_q <= req_addr[gnt_idx*AW +: AW];
    end

    assign rsp_valid = rd_pend_q ? (NREQ'(1) << rd_id_q) : '0;
    assign rsp_rdata = mem_rdata;
    assign owner     = owner_q;
    assign locked    = (state_q == LOCKED);

`ifndef SYNTHESIS
    // A stalled requester must keep its beat unchanged until accepted
    for (genvar i = 0; i < NREQ; i++) begin : g_proto
        a_hold_stable : assert property (@(posedge clk) disable iff (!rst_n)
            (req_valid[i] && !req_ready[i]) |=>
            (!req_valid[i] || $stable({req_we[i], req_lock[i],
                                       req_addr[i*AW +: AW],
                                       req_wdata[i*WIDTH +: WIDTH]})));
    end
`endif

endmodule

// File: tb/tb_data_memory_arbiter.sv
// Directed bench for data_memory_arbiter with NREQ=2, MAX_BURST=4 driving a
// real data_memory instance.
module tb_data_memory_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  req_valid, req_we, req_lock;
    logic [15:0] req_addr, req_wdata;
    logic [1:0]  req_ready, rsp_valid;
    logic [7:0]  rsp_rdata;
    logic        mem_we;
    logic [7:0]  mem_addr, mem_wdata, mem_rdata;
    logic [0:0]  owner;
    logic        locked;

    int n_checks = 0;
    int n_fail   = 0;

    int exp_gnt3   [6] = '{0, 1, 0, 1, 0, 1};
    int exp_ready5 [8] = '{1, 1, 1, 1, 2, 1, 1, 1};
    int exp_lock5  [8] = '{0, 1, 1, 1, 0, 0, 1, 1};

    always #5 clk = ~clk;

    data_memory_arbiter #(.WIDTH(8), .DEPTH(256), .NREQ(2), .MAX_BURST(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_we    (req_we),
        .req_lock  (req_lock),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .owner     (owner),
        .locked    (locked)
    );

    data_memory #(.WIDTH(8), .DEPTH(256)) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .addr  (mem_addr),
        .wdata (mem_wdata),
        .rdata (mem_rdata)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] exp_rv, exp_rd;
        int n0, n1, prev;

        // Reset state, with requests already presented
        rst_n = 1'b0; req_valid = 2'b11; req_we = 2'b01; req_lock = 2'b00;
        req_addr = 16'h0000; req_wdata = 16'h00FF;
        @(negedge clk); #1;
        check_val("rst_ready",     32'(req_ready), 32'h0);
        check_val("rst_mem_we",    32'(mem_we),    32'h0);
        check_val("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        check_val("rst_locked",    32'(locked),    32'h0);

        // 1. Read accepted, then reset right after the accepting edge
        @(negedge clk);
        rst_n = 1'b1; req_valid = 2'b01; req_we = 2'b00; req_addr = 16'h0010;
        #1;
        check_val("t1_ready", 32'(req_ready), 32'h1);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check_val("t1_rsp_dropped", 32'(rsp_valid), 32'h0);
        check_val("t1_ready_rst",   32'(req_ready), 32'h0);
        check_val("t1_mem_we_rst",  32'(mem_we),    32'h0);
        @(negedge clk); req_valid = 2'b00;
        @(negedge clk); rst_n = 1'b1;

        // 2. R0 writes 0xA5 @0x10, then reads it back
        @(negedge clk);
        req_valid = 2'b01; req_we = 2'b01; req_addr = 16'h0010; req_wdata = 16'h00A5;
        #1;
        check_val("t2_wr_ready", 32'(req_ready), 32'h1);
        check_val("t2_wr_we",    32'(mem_we),    32'h1);
        check_val("t2_wr_addr",  32'(mem_addr),  32'h10);
        check_val("t2_wr_data",  32'(mem_wdata), 32'hA5);
        @(negedge clk);
        req_we = 2'b00;
        #1;
        check_val("t2_rd_ready", 32'(req_ready), 32'h1);
        check_val("t2_rd_we",    32'(mem_we),    32'h0);
        check_val("t2_no_rsp",   32'(rsp_valid), 32'h0);
        @(negedge clk);
        req_valid = 2'b00;
        #1;
        check_val("t2_rsp_valid", 32'(rsp_valid), 32'h1);
        check_val("t2_rsp_rdata", 32'(rsp_rdata), 32'hA5);
        check_val("t2_idle_ready", 32'(req_ready), 32'h0);
        check_val("t2_idle_addr",  32'(mem_addr),  32'h10);

        // Preload 0x20..0x27 with 0x30..0x37
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            req_valid = 2'b01; req_we = 2'b01;
            req_addr = {8'h00, 8'(32 + k)}; req_wdata = {8'h00, 8'(48 + k)};
        end
        @(negedge clk); req_valid = 2'b00; req_we = 2'b00;

        // 3. Contention from reset, no lock: grants alternate R0, R1
        rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        n0 = 0; n1 = 0; exp_rv = 32'h0; exp_rd = 32'h0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            req_valid = 2'b11; req_we = 2'b00; req_lock = 2'b00;
            req_addr = {8'(36 + n1), 8'(32 + n0)};
            #1;
            check_val("t3_ready",     32'(req_ready), 32'(1 << exp_gnt3[k]));
            check_val("t3_rsp_valid", 32'(rsp_valid), exp_rv);
            if (exp_rv != 32'h0) check_val("t3_rsp_rdata", 32'(rsp_rdata), exp_rd);
            if (exp_gnt3[k] == 0) begin
                exp_rd = 32'(48 + n0); n0++;
            end else begin
                exp_rd = 32'(52 + n1); n1++;
            end
            exp_rv = 32'(1 << exp_gnt3[k]);
        end
        @(negedge clk);
        req_valid = 2'b00;
        #1;
        check_val("t3_last_rsp_valid", 32'(rsp_valid), 32'h2);
        check_val("t3_last_rsp_rdata", 32'(rsp_rdata), 32'h36);

        // 4. R1 locks for 3 write beats while R0 waits, then releases
        @(negedge clk);
        req_valid = 2'b10; req_we = 2'b10; req_lock = 2'b10;
        req_addr = {8'h40, 8'h00}; req_wdata = {8'h50, 8'h00};
        #1;
        check_val("t4_b1_ready",  32'(req_ready), 32'h2);
        check_val("t4_b1_locked", 32'(locked),    32'h0);
        @(negedge clk);
        req_valid = 2'b11; req_addr = {8'h41, 8'h40}; req_wdata = {8'h51, 8'h00};
        #1;
        check_val("t4_b2_ready",  32'(req_ready), 32'h2);
        check_val("t4_b2_locked", 32'(locked),    32'h1);
        check_val("t4_b2_owner",  32'(owner),     32'h1);
        @(negedge clk);
        req_lock = 2'b00; req_addr = {8'h42, 8'h40}; req_wdata = {8'h52, 8'h00};
        #1;
        check_val("t4_b3_ready",  32'(req_ready), 32'h2);
        check_val("t4_b3_locked", 32'(locked),    32'h1);
        @(negedge clk);
        req_we = 2'b00; req_addr = {8'h41, 8'h40};
        #1;
        check_val("t4_r0_ready",  32'(req_ready), 32'h1);
        check_val("t4_r0_locked", 32'(locked),    32'h0);
        @(negedge clk);
        req_valid = 2'b10;
        #1;
        check_val("t4_r1_ready",     32'(req_ready), 32'h2);
        check_val("t4_r0_rsp_valid", 32'(rsp_valid), 32'h1);
        check_val("t4_r0_rsp_rdata", 32'(rsp_rdata), 32'h50);
        @(negedge clk);
        req_valid = 2'b00;
        #1;
        check_val("t4_r1_rsp_valid", 32'(rsp_valid), 32'h2);
        check_val("t4_r1_rsp_rdata", 32'(rsp_rdata), 32'h51);

        // 5. R0 keeps lock asserted; capped at 4 beats, R1 gets one, R0 relocks
        prev = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            req_valid = (k <= 4) ? 2'b11 : 2'b01;
            req_we = 2'b00; req_lock = 2'b01;
            req_addr = {8'h24, 8'h20};
            #1;
            check_val("t5_ready",  32'(req_ready), 32'(exp_ready5[k]));
            check_val("t5_locked", 32'(locked),    32'(exp_lock5[k]));
            if (k > 0) begin
                check_val("t5_rsp_valid", 32'(rsp_valid), 32'(prev));
                check_val("t5_rsp_rdata", 32'(rsp_rdata), (prev == 1) ? 32'h30 : 32'h34);
            end
            prev = exp_ready5[k];
        end
        @(negedge clk);
        req_lock = 2'b00;
        #1;
        check_val("t5_rel_ready",  32'(req_ready), 32'h1);
        check_val("t5_rel_locked", 32'(locked),    32'h1);
        @(negedge clk);
        req_valid = 2'b00;
        #1;
        check_val("t5_after_locked", 32'(locked), 32'h0);

        // 6. Owner idles while locked, then releases while idle
        @(negedge clk);
        req_valid = 2'b01; req_we = 2'b01; req_lock = 2'b01;
        req_addr = {8'h61, 8'h60}; req_wdata = {8'h88, 8'h77};
        #1;
        check_val("t6_entry_ready", 32'(req_ready), 32'h1);
        check_val("t6_entry_we",    32'(mem_we),    32'h1);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            req_valid = 2'b10; req_we = 2'b10;
            #1;
            check_val("t6_idle_ready",  32'(req_ready), 32'h0);
            check_val("t6_idle_we",     32'(mem_we),    32'h0);
            check_val("t6_idle_locked", 32'(locked),    32'h1);
            check_val("t6_idle_addr",   32'(mem_addr),  32'h60);
        end
        @(negedge clk);
        req_lock = 2'b00;
        #1;
        check_val("t6_rel_ready",  32'(req_ready), 32'h0);
        check_val("t6_rel_locked", 32'(locked),    32'h1);
        @(negedge clk);
        #1;
        check_val("t6_arb_locked", 32'(locked),    32'h0);
        check_val("t6_arb_ready",  32'(req_ready), 32'h2);
        check_val("t6_arb_we",     32'(mem_we),    32'h1);
        check_val("t6_arb_addr",   32'(mem_addr),  32'h61);
        @(negedge clk);
        req_valid = 2'b01; req_we = 2'b00;
        #1;
        check_val("t6_rd0_ready", 32'(req_ready), 32'h1);
        @(negedge clk);
        req_valid = 2'b10;
        #1;
        check_val("t6_rd1_ready",     32'(req_ready), 32'h2);
        check_val("t6_rd0_rsp_valid", 32'(rsp_valid), 32'h1);
        check_val("t6_rd0_rsp_rdata", 32'(rsp_rdata), 32'h77);
        @(negedge clk);
        req_valid = 2'b00;
        #1;
        check_val("t6_rd1_rsp_valid", 32'(rsp_valid), 32'h2);
        check_val("t6_rd1_rsp_rdata", 32'(rsp_rdata), 32'h88);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
